// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg -- shared definitions for the M-extension multiply/divide unit.
//   * op_e    : funct3 encoding of the eight M-extension operations
//   * state_e : control FSM states (IDLE / CALC / DONE)
//   * XLEN_DEFAULT / TAG_W_DEFAULT : default operand and tag widths
//   * small decode helpers used by the unit to classify an op
// Build option: MULDIV_FAST_MUL_EN (see muldiv_unit) selects a single-cycle
// multiplier instead of the iterative shift-add path.
// -----------------------------------------------------------------------------
package muldiv_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int TAG_W_DEFAULT = 5;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Divide/remainder ops all have funct3[2] set.
  function automatic logic op_is_div(input op_e op);
    return op[2];
  endfunction

  function automatic logic op_is_rem(input op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  // rs1 is treated as two's complement for these ops. MUL is left unsigned:
  // the low half of the product does not depend on operand signedness.
  function automatic logic op_signed_a(input op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_signed_b(input op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// -----------------------------------------------------------------------------
// muldiv_if -- EX-stage <-> multiply/divide unit bundle.
//   master (pipeline side): drives valid_i, op_i, rs1_i, rs2_i, rd_i, kill_i;
//                           observes ready_o, busy_o, valid_o, result_o, rd_o
//   slave  (unit side)    : the reverse
// Signal names keep the unit-relative _i/_o suffixes so both ends read the
// same way.
// -----------------------------------------------------------------------------
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int TAG_W = TAG_W_DEFAULT
) ();

  logic             valid_i;
  logic [2:0]       op_i;
  logic [XLEN-1:0]  rs1_i;
  logic [XLEN-1:0]  rs2_i;
  logic [TAG_W-1:0] rd_i;
  logic             kill_i;
  logic             ready_o;
  logic             busy_o;
  logic             valid_o;
  logic [XLEN-1:0]  result_o;
  logic [TAG_W-1:0] rd_o;

  modport master (
    output valid_i, op_i, rs1_i, rs2_i, rd_i, kill_i,
    input  ready_o, busy_o, valid_o, result_o, rd_o
  );

  modport slave (
    input  valid_i, op_i, rs1_i, rs2_i, rd_i, kill_i,
    output ready_o, busy_o, valid_o, result_o, rd_o
  );

endinterface

// File: rtl/muldiv_div_iter.sv
// -----------------------------------------------------------------------------
// muldiv_div_iter -- restoring unsigned divider, one quotient bit per step.
//   clk_i, rst_i : clock, synchronous active-low reset
//   start_i      : load magnitudes, clear remainder and step counter
//   step_i       : perform one restoring step
//   dividend_i   : |rs1| (loaded on start_i)
//   divisor_i    : |rs2| (loaded on start_i)
//   quo_nxt_o    : quotient after the current step (combinational)
//   rem_nxt_o    : remainder after the current step (combinational)
//   last_o       : the current step is step XLEN (final bit)
// The "next" outputs let the caller capture the finished result on the same
// edge that performs the last step, so no extra drain cycle is needed. The
// step counter doubles as the iteration timer for the shift-add multiplier.
// -----------------------------------------------------------------------------
module muldiv_div_iter
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quo_nxt_o,
  output logic [XLEN-1:0] rem_nxt_o,
  output logic            last_o
);

  localparam int CNT_W = $clog2(XLEN);

  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [XLEN:0]    shifted;
  logic             fits;

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    // Quotient register holds the not-yet-consumed dividend bits in its top
    // end; each step shifts one of them into the partial remainder.
    shifted   = {rem_q, quo_q[XLEN-1]};
    fits      = (shifted >= {1'b0, dvs_q});
    rem_nxt_o = fits ? (shifted[XLEN-1:0] - dvs_q) : shifted[XLEN-1:0];
    quo_nxt_o = {quo_q[XLEN-2:0], fits};
    last_o    = (cnt_q == CNT_W'(XLEN - 1));

    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    if (start_i) begin
      rem_d = '0;
      quo_d = dividend_i;
      dvs_d = divisor_i;
      cnt_d = '0;
    end else if (step_i) begin
      rem_d = rem_nxt_o;
      quo_d = quo_nxt_o;
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: clocked state uses non-blocking assignments only; reset is sampled
  // synchronously on the rising edge and clears every accumulator.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit -- RISC-V M-extension multiply/divide unit for the EX stage.
//   clk_i  : clock, all state changes on the rising edge
//   rst_i  : synchronous active-low reset
//   bus    : muldiv_if.slave
//            valid_i/op_i/rs1_i/rs2_i/rd_i : op request (accepted when
//                                            valid_i & ready_o & !kill_i)
//            kill_i   : pipeline flush, abandons any op in flight
//            ready_o  : IDLE and out of reset
//            busy_o   : op in flight (CALC or DONE), stalls the pipeline
//            valid_o  : one-cycle result pulse in DONE
//            result_o/rd_o : result and echoed tag, held while valid_o=0
// Timing: accept edge is cycle 0. Iterative ops compute in CALC for cycles
// 1..XLEN and pulse valid_o in DONE at cycle XLEN+1. Divide by zero and
// signed overflow go straight to DONE at cycle 1.
// Build option MULDIV_FAST_MUL_EN: multiplies use a single-cycle
// XLEN x XLEN multiplier and finish at cycle 1; otherwise they use the
// iterative shift-add path. Divide behaviour is the same in both builds.
// -----------------------------------------------------------------------------
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int TAG_W = TAG_W_DEFAULT
) (
  input  logic    clk_i,
  input  logic    rst_i,
  muldiv_if.slave bus
);

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;       // tag of the op in flight
  logic             neg_q, neg_d;       // negate the magnitude result
  logic [XLEN-1:0]  res_q, res_d;       // result presented during DONE
  logic [XLEN-1:0]  result_q, result_d; // last delivered result
  logic [TAG_W-1:0] rd_q, rd_d;         // last delivered tag

  op_e              op_in;
  logic             a_sgn, b_sgn;
  logic [XLEN-1:0]  a_abs, b_abs;
  logic             div_zero, div_ovf, accept;

  logic             div_start, div_step, div_last;
  logic [XLEN-1:0]  quo_nxt, rem_nxt;
  logic [XLEN-1:0]  q_fix, r_fix, div_res;

  // Multiply path selection: mul_now means a multiply completes on the
  // accept edge; mul_calc_res is the finished product at the end of CALC.
  logic             mul_now;
  logic [XLEN-1:0]  mul_now_res;
  logic [XLEN-1:0]  mul_calc_res;

  assign bus.ready_o = (state_q == ST_IDLE) & rst_i;
  assign bus.busy_o  = (state_q != ST_IDLE) & rst_i;
  assign bus.valid_o = (state_q == ST_DONE) & ~bus.kill_i & rst_i;
  // A killed DONE never overwrites the held result/tag.
  assign bus.result_o = bus.valid_o ? res_q : result_q;
  assign bus.rd_o     = bus.valid_o ? tag_q : rd_q;

  // Operand decode: both datapaths work on magnitudes; the sign is applied
  // once at the end.
  always_comb begin
    op_in    = op_e'(bus.op_i);
    a_sgn    = op_signed_a(op_in) & bus.rs1_i[XLEN-1];
    b_sgn    = op_signed_b(op_in) & bus.rs2_i[XLEN-1];
    a_abs    = a_sgn ? -bus.rs1_i : bus.rs1_i;
    b_abs    = b_sgn ? -bus.rs2_i : bus.rs2_i;
    div_zero = (bus.rs2_i == '0);
    div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
               (bus.rs1_i == MOST_NEG) && (bus.rs2_i == '1);
    accept   = bus.valid_i & bus.ready_o & ~bus.kill_i;
  end

  muldiv_div_iter #(.XLEN(XLEN)) u_div_iter (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (div_start),
    .step_i     (div_step),
    .dividend_i (a_abs),
    .divisor_i  (b_abs),
    .quo_nxt_o  (quo_nxt),
    .rem_nxt_o  (rem_nxt),
    .last_o     (div_last)
  );

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] a_ext, b_ext, fast_prod;

  // Sign/zero extension to 2*XLEN makes one unsigned multiply cover all
  // four signedness combinations.
  always_comb begin
    a_ext        = {{XLEN{a_sgn}}, bus.rs1_i};
    b_ext        = {{XLEN{b_sgn}}, bus.rs2_i};
    fast_prod    = a_ext * b_ext;
    mul_now      = 1'b1;
    mul_now_res  = (op_in == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    mul_calc_res = '0;
  end
`else
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [2*XLEN-1:0] prod_step, prod_fix;
  logic [XLEN:0]     mul_sum;

  // Shift-add: the low half of prod starts as the multiplier and is shifted
  // out while the partial product grows into the high half.
  always_comb begin
    mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_step = {mul_sum, prod_q[XLEN-1:1]};
    prod_fix  = neg_q ? -prod_step : prod_step;

    mul_now      = 1'b0;
    mul_now_res  = '0;
    mul_calc_res = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];

    mcand_d = mcand_q;
    prod_d  = prod_q;
    if (accept) begin
      mcand_d = a_abs;
      prod_d  = {{XLEN{1'b0}}, b_abs};
    end else if (state_q == ST_CALC) begin
      prod_d  = prod_step;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      mcand_q <= '0;
      prod_q  <= '0;
    end else begin
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
    end
  end
`endif

  always_comb begin
    q_fix   = neg_q ? -quo_nxt : quo_nxt;
    r_fix   = neg_q ? -rem_nxt : rem_nxt;
    div_res = op_is_rem(op_q) ? r_fix : q_fix;

    state_d   = state_q;
    op_d      = op_q;
    tag_d     = tag_q;
    neg_d     = neg_q;
    res_d     = res_q;
    result_d  = result_q;
    rd_d      = rd_q;
    div_start = 1'b0;
    div_step  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d  = op_in;
          tag_d = bus.rd_i;
          // Remainder takes the dividend's sign; everything else the XOR.
          neg_d = op_is_rem(op_in) ? a_sgn : (a_sgn ^ b_sgn);
          if (op_is_div(op_in) && div_zero) begin
            state_d = ST_DONE;
            res_d   = op_is_rem(op_in) ? bus.rs1_i : '1;
          end else if (div_ovf) begin
            state_d = ST_DONE;
            res_d   = op_is_rem(op_in) ? '0 : bus.rs1_i;
          end else if (!op_is_div(op_in) && mul_now) begin
            state_d = ST_DONE;
            res_d   = mul_now_res;
          end else begin
            state_d   = ST_CALC;
            div_start = 1'b1;
          end
        end
      end
      ST_CALC: begin
        if (bus.kill_i) begin
          state_d = ST_IDLE;
        end else begin
          div_step = 1'b1;
          if (div_last) begin
            state_d = ST_DONE;
            res_d   = op_is_div(op_q) ? div_res : mul_calc_res;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (!bus.kill_i) begin
          result_d = res_q;
          rd_d     = tag_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MUL;
      tag_q    <= '0;
      neg_q    <= 1'b0;
      res_q    <= '0;
      result_q <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      tag_q    <= tag_d;
      neg_q    <= neg_d;
      res_q    <= res_d;
      result_q <= result_d;
      rd_q     <= rd_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit -- self-checking bench for muldiv_unit at XLEN=32.
// Directed vector table, hand-written kill/reset/handshake sequences, and
// randomized ops compared against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = XLEN + 1;
`endif
  localparam int DIV_LAT = XLEN + 1;
  localparam int N_VEC   = 14;
  localparam int N_RAND  = 150;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    op_e         op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs [N_VEC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference model straight from the M-extension rules, in 64-bit arithmetic.
  function automatic logic [31:0] model(input op_e op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      OP_MUL:    begin p = ua * ub;                 return p[31:0];  end
      OP_MULH:   begin p = sa * sb;                 return p[63:32]; end
      OP_MULHSU: begin p = sa * ub;                 return p[63:32]; end
      OP_MULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      OP_DIV:    return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
      OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      OP_REM:    return (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
      OP_REMU:   return (b == 0) ? a : 32'(ua % ub);
      default:   return 32'd0;
    endcase
  endfunction

  function automatic int model_lat(input op_e op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return MUL_LAT;
    if (b == 0) return 1;
    if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return DIV_LAT;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Leaves the caller at a negedge with ready_o high (bounded wait).
  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (bus.ready_o !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("ready_timeout", 64'(bus.ready_o), 64'd1);
  endtask

  // Called at a negedge with ready_o high; accept happens on the next edge
  // (cycle 0). Returns the cycle index of the valid_o pulse, 0 on timeout.
  task automatic issue_op(input op_e op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output logic [31:0] res,
                          output logic [4:0] rdo, output int lat);
    bus.valid_i = 1'b1;
    bus.op_i    = op;
    bus.rs1_i   = a;
    bus.rs2_i   = b;
    bus.rd_i    = rd;
    lat = 0;
    res = '0;
    rdo = '0;
    for (int k = 1; k <= DIV_LAT + 8; k++) begin
      @(negedge clk);
      if (k == 1) bus.valid_i = 1'b0;
      if (bus.valid_o === 1'b1) begin
        lat = k;
        res = bus.result_o;
        rdo = bus.rd_o;
        break;
      end
    end
  endtask

  task automatic run_and_check(input string name, input op_e op, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd,
                               input logic [31:0] exp, input int exp_lat);
    logic [31:0] res;
    logic [4:0]  rdo;
    int          lat;
    wait_ready();
    issue_op(op, a, b, rd, res, rdo, lat);
    check({name, "_result"}, 64'(res), 64'(exp));
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    check({name, "_rd"}, 64'(rdo), 64'(rd));
    @(negedge clk);
    check({name, "_hold"}, {31'd0, bus.valid_o, bus.result_o}, {32'd0, exp});
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] res, a, b, exp;
    logic [4:0]  rdo;
    int          lat;
    logic        seen;
    op_e         op;

    vecs[0]  = '{OP_DIV,    32'hFFFF_FFF9, 32'd2,         5'd1,  32'hFFFF_FFFD, DIV_LAT};
    vecs[1]  = '{OP_REM,    32'hFFFF_FFF9, 32'd2,         5'd2,  32'hFFFF_FFFF, DIV_LAT};
    vecs[2]  = '{OP_DIVU,   32'd100,       32'd0,         5'd3,  32'hFFFF_FFFF, 1};
    vecs[3]  = '{OP_REMU,   32'd100,       32'd0,         5'd4,  32'd100,       1};
    vecs[4]  = '{OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd5,  32'h8000_0000, 1};
    vecs[5]  = '{OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd6,  32'd0,         1};
    vecs[6]  = '{OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'd0,         MUL_LAT};
    vecs[7]  = '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFE, MUL_LAT};
    vecs[8]  = '{OP_MUL,    32'd7,         32'd6,         5'd9,  32'd42,        MUL_LAT};
    vecs[9]  = '{OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 32'hFFFF_FFFF, MUL_LAT};
    vecs[10] = '{OP_DIV,    32'd7,         32'hFFFF_FFFE, 5'd11, 32'hFFFF_FFFD, DIV_LAT};
    vecs[11] = '{OP_REM,    32'd7,         32'hFFFF_FFFE, 5'd12, 32'd1,         DIV_LAT};
    vecs[12] = '{OP_DIVU,   32'hFFFF_FFFF, 32'd1,         5'd13, 32'hFFFF_FFFF, DIV_LAT};
    vecs[13] = '{OP_REM,    32'hFFFF_FFF8, 32'd0,         5'd14, 32'hFFFF_FFF8, 1};

    rst         = 1'b0;
    bus.valid_i = 1'b0;
    bus.op_i    = 3'd0;
    bus.rs1_i   = '0;
    bus.rs2_i   = '0;
    bus.rd_i    = '0;
    bus.kill_i  = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(bus.ready_o), 64'd0);
    check("rst_busy",  64'(bus.busy_o),  64'd0);
    check("rst_valid", 64'(bus.valid_o), 64'd0);
    check("rst_result_rd", {27'd0, bus.rd_o, bus.result_o}, 64'd0);
    rst = 1'b1;
    #1;
    check("rst_release_ready", 64'(bus.ready_o), 64'd1);

    // Directed vectors.
    for (int i = 0; i < N_VEC; i++)
      run_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                    vecs[i].rd, vecs[i].exp, vecs[i].lat);

    // Kill during CALC at cycle 10, then a fresh op at cycle 11.
    wait_ready();
    bus.valid_i = 1'b1; bus.op_i = OP_DIVU; bus.rs1_i = 32'd1000; bus.rs2_i = 32'd3; bus.rd_i = 5'd20;
    seen = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) bus.valid_i = 1'b0;
      if (bus.valid_o === 1'b1) seen = 1'b1;
      if (k == 5) check("calc_busy_ready", {bus.busy_o, bus.ready_o}, 64'b10);
      if (k == 10) bus.kill_i = 1'b1;
    end
    @(negedge clk);
    bus.kill_i = 1'b0;
    check("kill_no_valid", 64'(seen), 64'd0);
    check("kill_ready_c11", 64'(bus.ready_o), 64'd1);
    check("kill_hold_result", 64'(bus.result_o), 64'(vecs[N_VEC-1].exp));
    issue_op(OP_DIVU, 32'd1000, 32'd7, 5'd21, res, rdo, lat);
    check("post_kill_result", 64'(res), 64'd142);
    check("post_kill_latency", 64'(lat), 64'(DIV_LAT));
    check("post_kill_rd", 64'(rdo), 64'd21);

    // Kill in DONE: no pulse, held outputs untouched.
    wait_ready();
    bus.valid_i = 1'b1; bus.op_i = OP_DIVU; bus.rs1_i = 32'd55; bus.rs2_i = 32'd0; bus.rd_i = 5'd22;
    @(negedge clk);
    bus.valid_i = 1'b0;
    bus.kill_i  = 1'b1;
    #1;
    check("kill_done_valid", 64'(bus.valid_o), 64'd0);
    @(negedge clk);
    bus.kill_i = 1'b0;
    check("kill_done_ready", 64'(bus.ready_o), 64'd1);
    check("kill_done_hold", {27'd0, bus.rd_o, bus.result_o}, {27'd0, 5'd21, 32'd142});

    // valid_i with kill_i in IDLE is not accepted.
    wait_ready();
    bus.valid_i = 1'b1; bus.kill_i = 1'b1; bus.op_i = OP_DIV; bus.rs1_i = 32'd9; bus.rs2_i = 32'd0;
    @(negedge clk);
    check("kill_idle_not_taken", {bus.busy_o, bus.ready_o}, 64'b01);
    bus.valid_i = 1'b0; bus.kill_i = 1'b0;

    // valid_i held through DONE: no overlapping accept.
    wait_ready();
    bus.valid_i = 1'b1; bus.op_i = OP_DIVU; bus.rs1_i = 32'd9; bus.rs2_i = 32'd0; bus.rd_i = 5'd23;
    @(negedge clk);
    check("done_valid_pulse", 64'(bus.valid_o), 64'd1);
    @(negedge clk);
    bus.valid_i = 1'b0;
    check("no_accept_in_done", {bus.busy_o, bus.ready_o}, 64'b01);

    // Randomized ops against the reference model.
    for (int i = 0; i < N_RAND; i++) begin
      op  = op_e'($urandom_range(0, 7));
      a   = pick_operand();
      b   = pick_operand();
      exp = model(op, a, b);
      run_and_check($sformatf("rand%0d_%s", i, op.name()), op, a, b,
                    5'($urandom), exp, model_lat(op, a, b));
    end

    // Reset at cycle 5 of a DIV.
    wait_ready();
    bus.valid_i = 1'b1; bus.op_i = OP_DIV; bus.rs1_i = 32'd1000; bus.rs2_i = 32'hFFFF_FFFD; bus.rd_i = 5'd31;
    seen = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) bus.valid_i = 1'b0;
      if (bus.valid_o === 1'b1) seen = 1'b1;
      if (k == 5) rst = 1'b0;
    end
    @(negedge clk);
    check("midrst_ready_busy_valid", {bus.ready_o, bus.busy_o, bus.valid_o}, 64'd0);
    check("midrst_outputs", {27'd0, bus.rd_o, bus.result_o}, 64'd0);
    rst = 1'b1;
    #1;
    check("midrst_release_ready", 64'(bus.ready_o), 64'd1);
    for (int k = 0; k < DIV_LAT + 5; k++) begin
      @(negedge clk);
      if (bus.valid_o === 1'b1) seen = 1'b1;
    end
    check("midrst_no_valid", 64'(seen), 64'd0);
    check("midrst_outputs_after", {27'd0, bus.rd_o, bus.result_o}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: XLEN, default 32, operand/result width in bits (8..64, power of two).
REQ-002 Parameter: TAG_W, default 5, destination-register tag width.
REQ-003 Port: clk_i  input  1  single clock; all state changes on rising edge.
REQ-004 Port: rst_i  input  1  reset, synchronous, active-low.
REQ-005 Port: valid_i  input  1  EX stage presents an M-extension op.
REQ-006 Port: op_i  input  3  funct3 code (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
REQ-007 Port: rs1_i, rs2_i  input  XLEN each  forwarded operands.
REQ-008 Port: rd_i  input  TAG_W  destination tag carried to the result.
REQ-009 Port: kill_i  input  1  pipeline flush; abandons any op.
REQ-010 Port: ready_o  output  1  unit can accept an op this cycle.
REQ-011 Port: busy_o  output  1  op in flight; drives hazard-unit stall.
REQ-012 Port: valid_o  output  1  result_o/rd_o valid, one-cycle pulse.
REQ-013 Port: result_o  output  XLEN  result; rd_o  output  TAG_W  echoed tag.

Function
REQ-014 States: IDLE, CALC, DONE; ready_o=1 only in IDLE with rst_i high; busy_o=1 in CALC and DONE.
REQ-015 Accept when valid_i & ready_o & !kill_i; operands, op and tag latched on that edge (cycle 0).
REQ-016 Iterative ops: CALC occupies cycles 1..XLEN (one quotient/product bit per cycle), DONE at cycle XLEN+1 with valid_o=1.
REQ-017 DONE always lasts one cycle, then IDLE; no new op accepted in DONE (no back-to-back overlap).
REQ-018 MUL returns low XLEN bits; MULH/MULHSU/MULHU return high XLEN bits of the 2*XLEN product with signed×signed, signed×unsigned, unsigned×unsigned operands.
REQ-019 DIV/REM signed, truncating toward zero, remainder sign = dividend sign; DIVU/REMU unsigned.
REQ-020 Divide by zero: quotient all-ones, remainder = rs1; skips CALC, DONE at cycle 1.
REQ-021 Signed overflow (rs1 = most-negative, rs2 = -1): DIV returns rs1, REM returns 0; DONE at cycle 1.
REQ-022 kill_i high in CALC or DONE: next state IDLE, valid_o forced 0 that cycle, result discarded.
REQ-023 kill_i and valid_i same cycle in IDLE: op not accepted.
REQ-024 result_o and rd_o hold last value while valid_o=0.

Reset
REQ-025 rst_i low at edge: state IDLE, valid_o=0, result_o=0, rd_o=0, internal accumulators 0; busy_o=0 and ready_o=0 while rst_i low.
REQ-026 Reset mid-operation discards the op; no valid_o after release.

Configuration
REQ-027 Macro MULDIV_FAST_MUL_EN defined: multiply ops use a single-cycle XLEN×XLEN multiplier, DONE at cycle 1.
REQ-028 Macro MULDIV_FAST_MUL_EN undefined: multiply ops use the iterative shift-add path, DONE at cycle XLEN+1; divide behaviour identical in both builds.

Structure
REQ-029 Package muldiv_pkg holds the op_i encoding constants (MUL=0 .. REMU=7), the state enum, and the XLEN default.
REQ-030 Sub-module muldiv_div_iter holds the restoring divide datapath (remainder, quotient, step counter); sign fix-up stays in muldiv_unit.

Verification (XLEN=32)
REQ-031 DIV rs1=-7, rs2=2 -> valid_o at cycle 33, result_o=0xFFFFFFFD (-3); REM same operands -> 0xFFFFFFFF (-1).
REQ-032 DIVU rs1=100, rs2=0 -> valid_o at cycle 1, result_o=0xFFFFFFFF; REMU -> 100.
REQ-033 DIV rs1=0x80000000, rs2=0xFFFFFFFF -> valid_o at cycle 1, result_o=0x80000000; REM -> 0.
REQ-034 MULH rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> 0x00000000; MULHU same -> 0xFFFFFFFE; valid_o at cycle 1 with MULDIV_FAST_MUL_EN, at cycle 33 without.
REQ-035 DIVU 1000/3 accepted, kill_i at cycle 10 -> no valid_o, ready_o=1 at cycle 11; new op accepted at cycle 11 completes correctly.
REQ-036 rst_i low at cycle 5 of DIV -> valid_o never pulses, all outputs 0 on release, ready_o=1 the first cycle rst_i is high.
